serial_word_receiver: RTL and testbench
=======================================

Name: serial_word_receiver

Overview:
Receiving end of the universal shift register's serial output. Samples the S_OUT bit stream produced in PUSH mode (left or right shift) and reassembles it into WIDTH-bit words. Buffers completed words in a small FIFO with a valid/ready handshake toward the consumer. Sits downstream of the register; the bench drives it with the register's S_OUT.

Parameters:
WIDTH, 4, word width in bits; matches the register data width D/Q.
DEPTH, 4, FIFO depth in words; power of two, at least 2.
LW, $clog2(DEPTH)+1, width of the LEVEL output.

Ports:
CLK  input  1  clock; all state updates on the rising edge.
RESET  input  1  synchronous, active-high reset.
ENB  input  1  bit-sample enable; S_IN is captured only when ENB=1.
S_IN  input  1  serial data bit, connected to the register's S_OUT.
DIR  input  1  bit order. 0 = MSB first (left shift); 1 = LSB first (right shift).
SYNC  input  1  word-boundary strobe; the bit sampled with SYNC=1 is bit 0 of a new word.
Q  output  WIDTH  FIFO head word; 0 when the FIFO is empty.
Q_VALID  output  1  FIFO is non-empty.
Q_READY  input  1  consumer accepts Q this cycle.
LEVEL  output  LW  number of words currently in the FIFO (0..DEPTH).
PEND  output  1  a partial word is in progress (bit counter != 0).
OVF  output  1  sticky overflow flag.
TOGGLES  output  32  sampled-bit transition count (see Optional Feature).

Behaviour:
- Synchronous, active-high reset: on a CLK edge with RESET=1, all of the following are cleared: shift register, bit counter, latched DIR, FIFO pointers, OVF and TOGGLES. After reset: Q=0, Q_VALID=0, LEVEL=0, PEND=0, OVF=0, TOGGLES=0. RESET has priority over every other input. RESET mid-word discards the partial word.
- Bit counter runs 0..WIDTH-1 and advances only on edges with ENB=1. When ENB=0, all state holds, except that a FIFO pop still occurs when its handshake conditions are met.
- DIR is latched on the edge that samples bit 0 of each word. Changes to DIR mid-word are ignored until the next word starts.
- Assembly when latched DIR=0: shift <= {shift[WIDTH-2:0], S_IN}.
- Assembly when latched DIR=1: shift <= {S_IN, shift[WIDTH-1:1]}.
- Word completion: on the edge that samples bit WIDTH-1, the completed word (including that bit) is written to the FIFO, and the bit counter returns to 0.
  - Q_VALID and LEVEL reflect the new word right after that edge, giving one cycle of latency from the last bit.
- SYNC=1 with ENB=1: the partial word is discarded, and the sampled bit becomes bit 0 of a new word (DIR is latched on that edge).
  - If the counter was already at 0, SYNC has no additional effect.
- SYNC=1 with ENB=0: ignored.
- Pop: occurs on an edge where Q_VALID=1 and Q_READY=1. The head advances. Q_READY is ignored when the FIFO is empty.
- Simultaneous push and pop: both take effect and LEVEL is unchanged. This is legal even when the FIFO is full, and OVF is not set.
- Push while full without a pop: the word is dropped and the FIFO is unchanged. OVF is set and stays at 1 until RESET.
- LEVEL never exceeds DEPTH. Pointers wrap modulo DEPTH.
- Q is driven from FIFO storage at the read pointer, masked to 0 when the FIFO is empty.

Optional Feature:
Macro PWR_CNT_EN enables the switching-activity counter used for power estimation.
- Defined: a previous-bit register (reset 0) holds the last sampled S_IN. On each edge with ENB=1, TOGGLES increments when S_IN differs from that register. TOGGLES saturates at 32'hFFFF_FFFF, and SYNC does not clear it.
- Undefined: no counter or previous-bit logic is generated, and TOGGLES is tied to 0. The port list is identical in both builds.

Test Plan:
1. MSB-first word: after RESET, DIR=0, ENB=1, S_IN=1,1,0,1 on 4 edges, Q_READY=0 -> after the 4th edge Q=4'hD, Q_VALID=1, LEVEL=1, PEND=0.
2. LSB-first word: DIR=1, S_IN=1,0,1,1 -> Q=4'hD. Toggle DIR to 0 after bit 1 of the next word (S_IN=0,1,1,0) -> that word still assembles LSB-first: Q (2nd entry)=4'h6.
3. Overflow: Q_READY=0, send words 1,2,3,4,5 -> LEVEL=4, OVF=1. Then Q_READY=1 drains 1,2,3,4, LEVEL returns to 0, and OVF stays 1.
4. SYNC resync: send bits 1,1, then SYNC=1 with bit 0, then bits 1,1,0 (DIR=0) -> exactly one word Q=4'h6, LEVEL=1. SYNC=1 with ENB=0 -> no effect.
5. Full FIFO with simultaneous push and pop: FIFO holds 4 words, Q_READY=1 on the edge the 5th word completes -> LEVEL stays 4, OVF=0, head advances. RESET asserted after 2 bits of a word -> PEND=0, LEVEL=0, Q=0.
6. PWR_CNT_EN defined: ENB=1, S_IN=0,1,0,1,1,1, with one ENB=0 cycle inserted where S_IN=0 -> TOGGLES=3. Without the macro -> TOGGLES=0.

Source files
------------

// File: rtl/serial_word_receiver.sv
// serial_word_receiver
//   Reassembles the serial S_OUT stream of a shift register into WIDTH-bit
//   words and buffers completed words in a DEPTH-entry FIFO with a
//   valid/ready handshake toward the consumer.
//
// Ports:
//   CLK      in   rising-edge clock
//   RESET    in   synchronous, active-high reset (highest priority)
//   ENB      in   bit-sample enable
//   S_IN     in   serial data bit
//   DIR      in   bit order: 0 = MSB first, 1 = LSB first (latched at bit 0)
//   SYNC     in   word-boundary strobe; sampled bit becomes bit 0 of a new word
//   Q        out  FIFO head word, 0 when empty
//   Q_VALID  out  FIFO non-empty
//   Q_READY  in   consumer accepts Q this cycle
//   LEVEL    out  number of words in the FIFO (0..DEPTH)
//   PEND     out  partial word in progress
//   OVF      out  sticky overflow flag (word dropped on a full FIFO)
//   TOGGLES  out  sampled-bit transition count
//
// Build option:
//   PWR_CNT_EN  when defined, TOGGLES counts transitions between consecutive
//               sampled bits (saturating). When undefined, TOGGLES is 0 and no
//               counter logic exists.

module serial_word_receiver #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned LW    = $clog2(DEPTH) + 1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             ENB,
  input  logic             S_IN,
  input  logic             DIR,
  input  logic             SYNC,
  output logic [WIDTH-1:0] Q,
  output logic             Q_VALID,
  input  logic             Q_READY,
  output logic [LW-1:0]    LEVEL,
  output logic             PEND,
  output logic             OVF,
  output logic [31:0]      TOGGLES
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned AW = LW - 1;

  // ---------------------------------------------------------------------------
  // Word assembly
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic             push;

  logic             word_start;
  logic             eff_dir;
  logic [WIDTH-1:0] base;
  logic [WIDTH-1:0] assembled;
  logic [CW-1:0]    eff_cnt;

  always_comb begin
    // A new word starts at counter 0 or on a SYNC strobe; SYNC drops the partial word.
    word_start = (cnt_q == '0) || SYNC;
    eff_dir    = word_start ? DIR : dir_q;
    base       = word_start ? '0 : shift_q;
    eff_cnt    = word_start ? '0 : cnt_q;
    if (eff_dir) begin
      assembled = {S_IN, base[WIDTH-1:1]};
    end else begin
      assembled = {base[WIDTH-2:0], S_IN};
    end
  end

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    push    = 1'b0;
    if (ENB) begin
      shift_d = assembled;
      dir_d   = eff_dir;
      if (eff_cnt == CW'(WIDTH - 1)) begin
        push  = 1'b1;
        cnt_d = '0;
      end else begin
        cnt_d = eff_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      shift_q <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
    end
  end

  assign PEND = (cnt_q != '0);

  // ---------------------------------------------------------------------------
  // FIFO: pointers carry one extra wrap bit so full and empty are distinct.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [LW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]    level;
  logic             full;
  logic             pop;
  logic             do_write;
  logic             ovf_q;

  always_comb begin
    level    = wr_ptr_q - rd_ptr_q;
    full     = (level == LW'(DEPTH));
    pop      = (level != '0) && Q_READY;
    // Full plus pop frees the head slot in the same edge, so the push is kept.
    do_write = push && (!full || pop);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (do_write) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (push && !do_write) begin
        ovf_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET && do_write) begin
      mem_q[wr_ptr_q[AW-1:0]] <= shift_d;
    end
  end

  assign LEVEL   = level;
  assign Q_VALID = (level != '0);
  assign Q       = Q_VALID ? mem_q[rd_ptr_q[AW-1:0]] : '0;
  assign OVF     = ovf_q;

  // ---------------------------------------------------------------------------
  // Switching-activity counter
  // ---------------------------------------------------------------------------
`ifdef PWR_CNT_EN
  logic        prev_q;
  logic [31:0] tog_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      prev_q <= 1'b0;
      tog_q  <= '0;
    end else if (ENB) begin
      prev_q <= S_IN;
      if ((S_IN != prev_q) && (tog_q != 32'hFFFF_FFFF)) begin
        tog_q <= tog_q + 32'd1;
      end
    end
  end

  assign TOGGLES = tog_q;
`else
  assign TOGGLES = '0;
`endif

endmodule

// File: tb/tb_serial_word_receiver.sv
// Randomized self-checking bench for serial_word_receiver against a
// queue-based reference model, plus a few directed word scenarios.

module tb_serial_word_receiver;

  localparam int W  = 4;
  localparam int D  = 4;
  localparam int LW = $clog2(D) + 1;

  logic          CLK = 1'b0;
  logic          RESET, ENB, S_IN, DIR, SYNC, Q_READY;
  logic [W-1:0]  Q;
  logic          Q_VALID, PEND, OVF;
  logic [LW-1:0] LEVEL;
  logic [31:0]   TOGGLES;

  serial_word_receiver #(.WIDTH(W), .DEPTH(D)) dut (
    .CLK(CLK), .RESET(RESET), .ENB(ENB), .S_IN(S_IN), .DIR(DIR), .SYNC(SYNC),
    .Q(Q), .Q_VALID(Q_VALID), .Q_READY(Q_READY), .LEVEL(LEVEL), .PEND(PEND),
    .OVF(OVF), .TOGGLES(TOGGLES)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int     m_bits[$];
  bit     m_dir;
  int     m_fifo[$];
  bit     m_ovf;
  longint m_tog;
  bit     m_prev;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input bit rst, input bit enb, input bit s, input bit dir,
                            input bit sync, input bit rdy);
    bit pop;
    bit have_word;
    int word;
    if (rst) begin
      m_bits.delete(); m_fifo.delete();
      m_dir = 0; m_ovf = 0; m_tog = 0; m_prev = 0;
      return;
    end
    pop = (m_fifo.size() > 0) && rdy;
    have_word = 0;
    word = 0;
    if (enb) begin
      if (sync || m_bits.size() == 0) begin
        m_bits.delete();
        m_dir = dir;
      end
      m_bits.push_back(int'(s));
      if (m_bits.size() == W) begin
        // Bit i is the i-th sampled bit of the word.
        for (int i = 0; i < W; i++) begin
          if (m_dir) word += m_bits[i] << i;
          else       word += m_bits[i] << (W - 1 - i);
        end
        have_word = 1;
        m_bits.delete();
      end
      if (s != m_prev && m_tog < 64'hFFFF_FFFF) m_tog++;
      m_prev = s;
    end
    if (pop) void'(m_fifo.pop_front());
    if (have_word) begin
      if (m_fifo.size() >= D) m_ovf = 1;
      else m_fifo.push_back(word);
    end
  endtask

  task automatic check_all();
    int exp_q;
    exp_q = (m_fifo.size() > 0) ? m_fifo[0] : 0;
    check("q", 32'(Q), 32'(exp_q));
    check("q_valid", 32'(Q_VALID), 32'(m_fifo.size() > 0));
    check("level", 32'(LEVEL), 32'(m_fifo.size()));
    check("pend", 32'(PEND), 32'(m_bits.size() != 0));
    check("ovf", 32'(OVF), 32'(m_ovf));
`ifdef PWR_CNT_EN
    check("toggles", TOGGLES, m_tog[31:0]);
`else
    check("toggles", TOGGLES, 32'd0);
`endif
  endtask

  task automatic step(input bit rst, input bit enb, input bit s, input bit dir,
                      input bit sync, input bit rdy);
    RESET = rst; ENB = enb; S_IN = s; DIR = dir; SYNC = sync; Q_READY = rdy;
    @(posedge CLK);
    model_edge(rst, enb, s, dir, sync, rdy);
    #1;
    check_all();
  endtask

  task automatic send_word(input logic [W-1:0] w, input bit rdy);
    for (int i = W - 1; i >= 0; i--) step(0, 1, w[i], 0, 0, rdy);
  endtask

  initial begin
    RESET = 1; ENB = 0; S_IN = 0; DIR = 0; SYNC = 0; Q_READY = 0;
    step(1, 0, 0, 0, 0, 0);
    check("reset_q", 32'(Q), 32'd0);

    // MSB-first word 1,1,0,1
    step(0, 1, 1, 0, 0, 0); step(0, 1, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0); step(0, 1, 1, 0, 0, 0);
    check("msb_word", 32'(Q), 32'hD);
    check("msb_level", 32'(LEVEL), 32'd1);

    // LSB-first word, then DIR flipped mid-word is ignored
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 1, 1, 0, 0); step(0, 1, 0, 1, 0, 0);
    step(0, 1, 1, 1, 0, 0); step(0, 1, 1, 1, 0, 0);
    step(0, 1, 0, 1, 0, 0); step(0, 1, 1, 1, 0, 0);
    step(0, 1, 1, 0, 0, 0); step(0, 1, 0, 0, 0, 0);
    check("lsb_word", 32'(Q), 32'hD);
    step(0, 0, 0, 0, 0, 1);
    check("lsb_dirhold", 32'(Q), 32'h6);

    // Overflow: five words into a four-deep FIFO, then drain
    step(1, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 5; k++) send_word(W'(k), 0);
    check("ovf_level", 32'(LEVEL), 32'd4);
    check("ovf_flag", 32'(OVF), 32'd1);
    for (int k = 1; k <= 4; k++) begin
      check("drain", 32'(Q), 32'(k));
      step(0, 0, 0, 0, 0, 1);
    end
    check("drain_ovf", 32'(OVF), 32'd1);

    // SYNC resync, and SYNC with ENB=0 ignored
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0); step(0, 1, 1, 0, 0, 0);
    step(0, 1, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 1, 1, 0, 0, 0); step(0, 1, 1, 0, 0, 0); step(0, 1, 0, 0, 0, 0);
    check("sync_word", 32'(Q), 32'h6);
    check("sync_level", 32'(LEVEL), 32'd1);

    // Full FIFO with simultaneous push and pop, then reset mid-word
    step(1, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 4; k++) send_word(W'(k + 8), 0);
    step(0, 1, 0, 0, 0, 0); step(0, 1, 1, 0, 0, 0); step(0, 1, 1, 0, 0, 0);
    step(0, 1, 1, 0, 0, 1);
    check("pp_level", 32'(LEVEL), 32'd4);
    check("pp_ovf", 32'(OVF), 32'd0);
    check("pp_head", 32'(Q), 32'd10);
    step(0, 1, 1, 0, 0, 0); step(0, 1, 0, 0, 0, 0);
    step(1, 1, 1, 0, 0, 0);
    check("rst_pend", 32'(PEND), 32'd0);
    check("rst_level", 32'(LEVEL), 32'd0);

    // Toggle count 0,1,0,1,[ENB=0,0],1,1
    step(0, 1, 0, 0, 0, 0); step(0, 1, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0); step(0, 1, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0); step(0, 1, 1, 0, 0, 0);
`ifdef PWR_CNT_EN
    check("toggles_dir", TOGGLES, 32'd3);
`else
    check("toggles_dir", TOGGLES, 32'd0);
`endif

    // Randomized phases with varying consumer readiness
    for (int ph = 0; ph < 6; ph++) begin
      int rdy_pct;
      rdy_pct = (ph % 3 == 0) ? 5 : ((ph % 3 == 1) ? 50 : 95);
      for (int c = 0; c < 500; c++) begin
        step(($urandom_range(0, 199) == 0),
             ($urandom_range(0, 99) < 75),
             1'($urandom),
             1'($urandom),
             ($urandom_range(0, 99) < 6),
             ($urandom_range(0, 99) < rdy_pct));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
